// File: rtl/proc_pkg.sv
// Shared types and constants for the processing-unit control sequencer.
package proc_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // Instruction word layout: {ldi, fs[3:0], rd[1:0], ra[1:0], rb[1:0]}
  localparam int INSTR_W = 11;
  localparam int LDI_POS = 10;
  localparam int FS_HI   = 9;
  localparam int FS_LO   = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 4;
  localparam int RA_HI   = 3;
  localparam int RA_LO   = 2;
  localparam int RB_HI   = 1;
  localparam int RB_LO   = 0;

  // Bit positions inside the {V,N,Z,C} flag vector
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Function-select codes understood by the functional unit
  localparam logic [3:0] FS_INC = 4'b0001;
  localparam logic [3:0] FS_ADD = 4'b0010;
  localparam logic [3:0] FS_SUB = 4'b0101;
  localparam logic [3:0] FS_AND = 4'b1000;

  // For a load-immediate the two source-register fields carry the 4-bit constant
  function automatic logic [3:0] imm_field(input logic [INSTR_W-1:0] ir);
    return {ir[RA_HI:RA_LO], ir[RB_HI:RB_LO]};
  endfunction

endpackage

// File: rtl/proc_control_unit_reg_file.sv
// Four general-purpose registers: one synchronous write port, three
// combinational read ports (two operand ports plus a debug port).
module reg_file #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [1:0]   waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [1:0]   ra_addr_i,
  output logic [N-1:0] ra_data_o,
  input  logic [1:0]   rb_addr_i,
  output logic [N-1:0] rb_data_o,
  input  logic [1:0]   dbg_addr_i,
  output logic [N-1:0] dbg_data_o
);

  logic [N-1:0] regs [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      logic [N-1:0] q;

      // Each register loads only when the write port addresses it
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (we_i && (waddr_i == 2'(gi))) begin
          q <= wdata_i;
        end
      end

      assign regs[gi] = q;
    end
  endgenerate

  assign ra_data_o  = regs[ra_addr_i];
  assign rb_data_o  = regs[rb_addr_i];
  assign dbg_data_o = regs[dbg_addr_i];

endmodule

// File: rtl/proc_control_unit.sv
// Hardwired sequencer: fetches one instruction over valid/ready, drives the
// external functional unit, then writes the result back and latches flags.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [N-1:0]       fu_a_o,
  output logic [N-1:0]       fu_b_o,
  output logic [3:0]         fu_fs_o,
  input  logic [N-1:0]       fu_f_i,
  input  logic [3:0]         fu_flags_i,
  output logic [3:0]         flags_o,
  output logic               done_o,
  input  logic [1:0]         dbg_addr_i,
  output logic [N-1:0]       dbg_data_o
);

  state_e             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [N-1:0]       res_q;
  logic [3:0]         flags_tmp_q;
  logic [3:0]         flags_q;
  logic [N-1:0]       fu_a_q;
  logic [N-1:0]       fu_b_q;
  logic [3:0]         fu_fs_q;
  logic               done_q;

  // Decoded fields of the held instruction
  logic       ir_ldi;
  logic [3:0] ir_fs;
  logic [1:0] ir_rd;
  logic [1:0] ir_ra;
  logic [1:0] ir_rb;

  assign ir_ldi = ir_q[LDI_POS];
  assign ir_fs  = ir_q[FS_HI:FS_LO];
  assign ir_rd  = ir_q[RD_HI:RD_LO];
  assign ir_ra  = ir_q[RA_HI:RA_LO];
  assign ir_rb  = ir_q[RB_HI:RB_LO];

  logic [N-1:0] ra_data;
  logic [N-1:0] rb_data;
  logic [N-1:0] imm_ext;
  logic [N-1:0] wr_data;
  logic         wr_en;

  // Size cast zero-extends for wide registers and keeps the LSBs for narrow ones
  assign imm_ext = N'(imm_field(ir_q));
  assign wr_en   = (state_q == WB);
  assign wr_data = ir_ldi ? imm_ext : res_q;

  reg_file #(.N(N)) u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wr_en),
    .waddr_i    (ir_rd),
    .wdata_i    (wr_data),
    .ra_addr_i  (ir_ra),
    .ra_data_o  (ra_data),
    .rb_addr_i  (ir_rb),
    .rb_data_o  (rb_data),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  // Sequencer with registered outputs; operands are captured in READ so rd may alias ra/rb
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      res_q       <= '0;
      flags_tmp_q <= '0;
      flags_q     <= '0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      fu_fs_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i) begin
            ir_q    <= instr_i;
            state_q <= instr_i[LDI_POS] ? WB : READ;
          end
        end
        READ: begin
          fu_a_q  <= ra_data;
          fu_b_q  <= rb_data;
          fu_fs_q <= ir_fs;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q       <= fu_f_i;
          flags_tmp_q <= fu_flags_i;
          state_q     <= WB;
        end
        WB: begin
          // The register write happens on this same edge, so done and the new value appear together
          done_q <= 1'b1;
          if (!ir_ldi) begin
            flags_q <= flags_tmp_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready_o = (state_q == IDLE) && !rst;
  assign fu_a_o        = fu_a_q;
  assign fu_b_o        = fu_b_q;
  assign fu_fs_o       = fu_fs_q;
  assign flags_o       = flags_q;
  assign done_o        = done_q;

endmodule

// File: doc/proc_control_unit.md
# proc_control_unit

- Hardwired sequencer for the processing unit.
- Accepts one instruction at a time over a valid/ready handshake and holds a 4-entry register file.
- Drives operand and function-select lines into the external functional unit (ALU + shifter), then writes the result back and latches the status flags.
- Sits between the instruction source (switches/testbench/upstream FSM) and the functional unit instance in the processing-unit top level.

## Interface

Parameters:

- N, 4, data width of registers and functional-unit operands

Ports:

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid_i  in  1  instruction present
- instr_ready_o  out  1  block can accept an instruction
- instr_i  in  11  {ldi, fs[3:0], rd[1:0], ra[1:0], rb[1:0]}
- fu_a_o  out  N  operand A to functional unit
- fu_b_o  out  N  operand B to functional unit
- fu_fs_o  out  4  function select to functional unit
- fu_f_i  in  N  functional-unit result (combinational from fu_a_o/fu_b_o/fu_fs_o)
- fu_flags_i  in  4  functional-unit flags {V,N,Z,C}
- flags_o  out  4  last latched flags {V,N,Z,C}
- done_o  out  1  one-cycle pulse when writeback completes
- dbg_addr_i  in  2  debug register read address
- dbg_data_o  out  N  combinational read of R[dbg_addr_i]

## Operation

FSM states: IDLE, READ, EXEC, WB.

- **IDLE**
  - instr_ready_o=1.
  - On instr_valid_i & instr_ready_o the instruction is latched into the instruction register (IR).
  - Next state: WB if ldi=1, else READ.
- **READ**
  - fu_a_o <= R[ra], fu_b_o <= R[rb], fu_fs_o <= fs. These are registered outputs.
  - Next state: EXEC.
- **EXEC**
  - Result register <= fu_f_i; flag register <= fu_flags_i.
  - Next state: WB.
- **WB**
  - ALU instruction: R[rd] <= result register; flags_o updates.
  - ldi=1: R[rd] <= zero-extended {ra,rb} (4-bit immediate); for N<4 it is truncated to N LSBs. flags_o is unchanged.
  - done_o=1 for this cycle only. Next state: IDLE.
- instr_ready_o is 0 in READ, EXEC and WB. instr_valid_i is ignored there; the source must hold its instruction until accepted.
- rd may equal ra or rb: operands are captured in READ, so there is no hazard.
- fu_a_o, fu_b_o and fu_fs_o hold their last values outside READ/EXEC.
- dbg_data_o reflects a WB write from the cycle after the write edge.
- All four registers are general purpose; none is hardwired to zero.

## Timing

- Reset values: state IDLE, R0–R3=0, fu_a_o=0, fu_b_o=0, fu_fs_o=0, flags_o=0, done_o=0. instr_ready_o=0 while rst=1, then 1 in IDLE.
- ALU instruction accepted at edge t: done_o high in the cycle after edge t+3; R[rd] visible after edge t+3. Latency 3 cycles.
- ldi accepted at edge t: done_o high after edge t+1. Latency 1 cycle.
- Maximum throughput: one ALU instruction per 4 cycles, one ldi per 2 cycles. instr_ready_o returns high the cycle after WB.
- rst asserted mid-operation: immediate abort, no writeback, all outputs and registers return to reset values.
- instr_valid_i asserted during WB: accepted on the first IDLE cycle, not during WB.

## Structure

- Package proc_pkg holds:
  - the state enum type (IDLE, READ, EXEC, WB);
  - instruction field bit positions/widths as localparams: LDI=10, FS=9:6, RD=5:4, RA=3:2, RB=1:0;
  - the flag index constants V=3, N=2, Z=1, C=0;
  - named FS constants: FS_ADD=4'b0010, FS_SUB=4'b0101, FS_AND=4'b1000, FS_INC=4'b0001.
- One sub-module, reg_file: 4×N registers, one synchronous write port, three combinational read ports (ra, rb, debug), asynchronous reset to zero.
- The FSM, IR, result register and flag register stay in proc_control_unit.

## Test plan

The bench instantiates the real functional unit.

1. **Reset:** pulse rst mid-EXEC → instr_ready_o=0 during reset, then 1; flags_o=0; R0–R3 read back 0 via the debug port; no done_o.
2. **Load immediate:** ldi R1=5 then ldi R2=3 → done_o one cycle after each accept; dbg_data_o=5 and 3.
3. **Add:** ADD R3=R1+R2 (fs=0010) → R3=8, flags_o=4'b1100 (V=1, N=1, Z=0, C=0); done_o exactly 3 cycles after accept.
4. **Subtract to zero:** SUB R0=R1−R1 (fs=0101) → R0=0, flags_o=4'b0011.
5. **AND with operand aliasing:** AND R1=R1&R2 (fs=1000) → R1=1.
6. **Back-to-back handshake:** instr_valid_i held high with two queued instructions → second accepted only on the cycle instr_ready_o returns high; no instruction lost or duplicated; an ldi between them leaves flags_o unchanged.
